// File: rtl/sort_data_loader_pkg.sv
// sort_data_loader_pkg: FSM encodings and sizing defaults shared with the data memory and sort CPU top
package sort_data_loader_pkg;
  localparam int N_WORDS_DEF         = 10;
  localparam int DATA_W_DEF          = 16;
  localparam int ADDR_W_DEF          = 4;
  localparam int LED_W_DEF           = 10;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/sort_data_loader_if.sv
// sort_data_loader_if: button/switch inputs and data-memory write/status outputs of the loader
interface sort_data_loader_if import sort_data_loader_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LED_W  = LED_W_DEF
);
  logic              btn_in;
  logic [DATA_W-1:0] sw_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [LED_W-1:0]  display_led;
  logic              over;
  logic              cpu_start;
  modport master (
    input  btn_in, sw_data,
    output wr_en, wr_addr, wr_data, display_led, over, cpu_start
  );
  modport slave (
    output btn_in, sw_data,
    input  wr_en, wr_addr, wr_data, display_led, over, cpu_start
  );
endinterface

// File: rtl/btn_debounce_edge.sv
// btn_debounce_edge: synchronises a raw button, accepts a level after DEBOUNCE_CYCLES stable cycles, pulses on accepted rise
module btn_debounce_edge import sort_data_loader_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic Clk,
  input  logic Clr,
  input  logic btn_in,
  output logic stable,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          btn_s, hit;
  assign btn_s = sync[1];
  assign hit   = (btn_s != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge Clk or posedge Clr)
    if (Clr) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync   <= {sync[0], btn_in};
      cnt    <= (btn_s == stable || hit) ? '0 : cnt + 1'b1;
      stable <= hit ? btn_s : stable;
      press  <= hit & btn_s;
    end
endmodule

// File: rtl/sort_data_loader.sv
// sort_data_loader: loads N_WORDS switch words into data memory on debounced presses, then starts the sort CPU
module sort_data_loader import sort_data_loader_pkg::*; #(
  parameter int N_WORDS         = N_WORDS_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int LED_W           = LED_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic              Clk,
  input logic              Clr,
  sort_data_loader_if.master bus
);
  if (N_WORDS > 2**ADDR_W || N_WORDS > LED_W) begin : g_bad_cfg
    $error("N_WORDS exceeds address space or LED count");
  end
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(N_WORDS - 1);
  localparam logic [LED_W-1:0]  LED_RST = {1'b1, {(LED_W-1){1'b0}}};
  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n, addr_n;
  logic [DATA_W-1:0] data_n;
  logic [LED_W-1:0]  led_n;
  logic              wr_en_n, over_n, start_n, stable, press;
  btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .Clk    (Clk),
    .Clr    (Clr),
    .btn_in (bus.btn_in),
    .stable (stable),
    .press  (press)
  );
  always_comb begin
    state_n = state;
    idx_n   = idx;
    addr_n  = bus.wr_addr;
    data_n  = bus.wr_data;
    led_n   = bus.display_led;
    over_n  = bus.over;
    wr_en_n = 1'b0;
    start_n = 1'b0;
    case (state)
      LOAD: if (press) begin
        state_n = WRITE;
        addr_n  = idx;
        data_n  = bus.sw_data;
        wr_en_n = 1'b1;
      end
      WRITE: if (idx == LAST) begin
        state_n = DONE;
        over_n  = 1'b1;
        start_n = 1'b1;
        led_n   = '0;
      end else begin
        state_n = RELEASE;
        idx_n   = idx + 1'b1;
        led_n   = bus.display_led >> 1;
      end
      // a bouncing release must fully settle low before the next press can arm
      RELEASE: state_n = stable ? RELEASE : LOAD;
      default: ;
    endcase
  end
  always_ff @(posedge Clk or posedge Clr)
    if (Clr) begin
      state           <= LOAD;
      idx             <= '0;
      bus.wr_en       <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
      bus.display_led <= LED_RST;
      bus.over        <= 1'b0;
      bus.cpu_start   <= 1'b0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      bus.wr_en       <= wr_en_n;
      bus.wr_addr     <= addr_n;
      bus.wr_data     <= data_n;
      bus.display_led <= led_n;
      bus.over        <= over_n;
      bus.cpu_start   <= start_n;
    end
endmodule

// File: tb/tb_sort_data_loader.sv
// tb_sort_data_loader: directed scenario bench for sort_data_loader with a short debounce window
module tb_sort_data_loader;
  logic Clk = 1'b0;
  logic Clr = 1'b1;
  int   pass = 0, total = 0;
  int   wr_cnt = 0, start_cnt = 0, start_bad = 0;
  logic [3:0]  last_addr = '0;
  logic [15:0] last_data = '0;
  sort_data_loader_if bus ();
  sort_data_loader #(.DEBOUNCE_CYCLES(4)) dut (.Clk(Clk), .Clr(Clr), .bus(bus));
  always #5 Clk = ~Clk;
  task automatic tick();
    @(posedge Clk);
    #1;
    if (bus.wr_en) begin
      wr_cnt++;
      last_addr = bus.wr_addr;
      last_data = bus.wr_data;
    end
    if (bus.cpu_start) begin
      start_cnt++;
      if (!bus.over) start_bad++;
    end
  endtask
  task automatic drive(input logic lvl, input int n);
    bus.btn_in = lvl;
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic do_reset();
    Clr = 1'b1;
    bus.btn_in = 1'b0;
    drive(1'b0, 3);
    Clr = 1'b0;
    drive(1'b0, 3);
    wr_cnt = 0;
    start_cnt = 0;
    start_bad = 0;
  endtask
  task automatic test_reset();
    Clr = 1'b1;
    bus.btn_in = 1'b0;
    bus.sw_data = 16'h0;
    drive(1'b0, 3);
    total++; if (bus.display_led !== 10'b1000000000) $display("FAIL reset_led got %b want %b", bus.display_led, 10'b1000000000); else pass++;
    total++; if (bus.over !== 1'b0) $display("FAIL reset_over got %b want 0", bus.over); else pass++;
    total++; if (bus.wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", bus.wr_en); else pass++;
    total++; if (bus.wr_addr !== 4'd0) $display("FAIL reset_wr_addr got %0d want 0", bus.wr_addr); else pass++;
    total++; if (bus.wr_data !== 16'h0) $display("FAIL reset_wr_data got %h want 0000", bus.wr_data); else pass++;
    total++; if (bus.cpu_start !== 1'b0) $display("FAIL reset_cpu_start got %b want 0", bus.cpu_start); else pass++;
    Clr = 1'b0;
    drive(1'b0, 3);
  endtask
  task automatic test_clean_press();
    wr_cnt = 0;
    bus.sw_data = 16'h00A5;
    drive(1'b1, 10);
    bus.sw_data = 16'hDEAD;
    drive(1'b0, 10);
    total++; if (wr_cnt !== 1) $display("FAIL clean_count got %0d want 1", wr_cnt); else pass++;
    total++; if (last_addr !== 4'd0) $display("FAIL clean_addr got %0d want 0", last_addr); else pass++;
    total++; if (last_data !== 16'h00A5) $display("FAIL clean_data got %h want 00a5", last_data); else pass++;
    total++; if (bus.wr_data !== 16'h00A5) $display("FAIL clean_hold got %h want 00a5", bus.wr_data); else pass++;
    total++; if (bus.display_led !== 10'b0100000000) $display("FAIL clean_led got %b want %b", bus.display_led, 10'b0100000000); else pass++;
  endtask
  task automatic test_bounce();
    wr_cnt = 0;
    bus.sw_data = 16'h0BEE;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2);
      drive(1'b0, 2);
    end
    drive(1'b1, 10);
    drive(1'b0, 10);
    total++; if (wr_cnt !== 1) $display("FAIL bounce_count got %0d want 1", wr_cnt); else pass++;
    total++; if (last_addr !== 4'd1) $display("FAIL bounce_addr got %0d want 1", last_addr); else pass++;
    total++; if (last_data !== 16'h0BEE) $display("FAIL bounce_data got %h want 0bee", last_data); else pass++;
    wr_cnt = 0;
    drive(1'b1, 3);
    drive(1'b0, 12);
    total++; if (wr_cnt !== 0) $display("FAIL glitch_count got %0d want 0", wr_cnt); else pass++;
    total++; if (bus.display_led !== 10'b0010000000) $display("FAIL glitch_led got %b want %b", bus.display_led, 10'b0010000000); else pass++;
  endtask
  task automatic test_ten_words();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      wr_cnt = 0;
      bus.sw_data = 16'(9 - k);
      drive(1'b1, 10);
      drive(1'b0, 10);
      total++; if (wr_cnt !== 1 || last_addr !== 4'(k) || last_data !== 16'(9 - k))
        $display("FAIL ten_write%0d got n=%0d addr=%0d data=%h want n=1 addr=%0d data=%h", k, wr_cnt, last_addr, last_data, k, 16'(9 - k));
      else pass++;
      if (k == 8) begin
        total++; if (bus.over !== 1'b0) $display("FAIL ten_over_early got %b want 0", bus.over); else pass++;
        total++; if (bus.display_led !== 10'b0000000001) $display("FAIL ten_led_last got %b want %b", bus.display_led, 10'b0000000001); else pass++;
      end
    end
    total++; if (bus.over !== 1'b1) $display("FAIL ten_over got %b want 1", bus.over); else pass++;
    total++; if (start_cnt !== 1) $display("FAIL ten_start_cycles got %0d want 1", start_cnt); else pass++;
    total++; if (start_bad !== 0) $display("FAIL ten_start_vs_over got %0d want 0", start_bad); else pass++;
    total++; if (bus.display_led !== 10'b0) $display("FAIL ten_led got %b want 0", bus.display_led); else pass++;
    wr_cnt = 0;
    bus.sw_data = 16'hFFFF;
    drive(1'b1, 10);
    drive(1'b0, 10);
    total++; if (wr_cnt !== 0) $display("FAIL extra_press got %0d want 0", wr_cnt); else pass++;
    total++; if (bus.over !== 1'b1 || bus.cpu_start !== 1'b0) $display("FAIL extra_over got over=%b start=%b want 1 0", bus.over, bus.cpu_start); else pass++;
    total++; if (start_cnt !== 1) $display("FAIL extra_start got %0d want 1", start_cnt); else pass++;
  endtask
  task automatic test_clr_mid_debounce();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.sw_data = 16'h1000 + 16'(k);
      drive(1'b1, 10);
      drive(1'b0, 10);
    end
    total++; if (wr_cnt !== 4 || last_addr !== 4'd3) $display("FAIL clr_pre got n=%0d addr=%0d want n=4 addr=3", wr_cnt, last_addr); else pass++;
    drive(1'b1, 4);
    Clr = 1'b1;
    #1;
    total++; if (bus.display_led !== 10'b1000000000 || bus.wr_addr !== 4'd0 || bus.wr_data !== 16'h0 || bus.over !== 1'b0 || bus.wr_en !== 1'b0)
      $display("FAIL clr_async got led=%b addr=%0d data=%h over=%b en=%b want reset values", bus.display_led, bus.wr_addr, bus.wr_data, bus.over, bus.wr_en);
    else pass++;
    drive(1'b1, 6);
    total++; if (bus.wr_en !== 1'b0 || bus.display_led !== 10'b1000000000) $display("FAIL clr_hold got en=%b led=%b want 0 reset", bus.wr_en, bus.display_led); else pass++;
    bus.btn_in = 1'b0;
    Clr = 1'b0;
    drive(1'b0, 5);
    wr_cnt = 0;
    bus.sw_data = 16'h1234;
    drive(1'b1, 10);
    drive(1'b0, 10);
    total++; if (wr_cnt !== 1 || last_addr !== 4'd0 || last_data !== 16'h1234)
      $display("FAIL clr_restart got n=%0d addr=%0d data=%h want n=1 addr=0 data=1234", wr_cnt, last_addr, last_data);
    else pass++;
    total++; if (bus.display_led !== 10'b0100000000) $display("FAIL clr_restart_led got %b want %b", bus.display_led, 10'b0100000000); else pass++;
  endtask
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_ten_words();
    test_clr_mid_debounce();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
